// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared IEEE-754 binary32 field definitions and helpers for the FPU
// sharing blocks (FMUL scheduler, later FADD scheduler).
//   EXP_MAX / EXP_BIAS : exponent limits
//   SIGN_W / EXP_W / FRAC_W : field widths
//   fp32_t             : packed {sign, exp, frac} view of a binary32 word
//   fp32_pack()        : assemble a binary32 word from its fields
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int unsigned SIGN_W   = 1;
   localparam int unsigned EXP_W    = 8;
   localparam int unsigned FRAC_W   = 23;
   localparam int unsigned EXP_BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   function automatic logic [31:0] fp32_pack(input logic [SIGN_W-1:0] sign,
                                             input logic [EXP_W-1:0]  exp,
                                             input logic [FRAC_W-1:0] frac);
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/fmul_core.sv
// -----------------------------------------------------------------------------
// fmul_core
// Combinational binary32 multiplier (truncating).
//   i_a, i_b   : packed binary32 operands
//   o_sign     : result sign
//   o_exp      : result exponent
//   o_frac     : result fraction, bits [23:1]
//   o_error    : invalid operation (inf * 0)
//   o_overflow : exponent overflow, result forced to inf
// Denormals are treated as zero; NaN inputs are handled as normals.
// -----------------------------------------------------------------------------
module fmul_core
   import fp_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_sign,
   output logic [7:0]  o_exp,
   output logic [23:1] o_frac,
   output logic        o_error,
   output logic        o_overflow
);

   fp32_t       w_a, w_b;
   logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf;
   logic [24:0] w_top;
   logic [9:0]  w_esum;

   assign w_a = i_a;
   assign w_b = i_b;

   assign w_a_zero = (w_a.exp == '0);
   assign w_b_zero = (w_b.exp == '0);
   assign w_a_inf  = (w_a.exp == EXP_MAX) && (w_a.frac == '0);
   assign w_b_inf  = (w_b.exp == EXP_MAX) && (w_b.frac == '0);

   // Product bits [47:23]: bit 24 flags a product in [2,4), the remaining
   // bits hold the truncated fraction for either normalisation case.
   assign w_top  = 25'((48'({1'b1, w_a.frac}) * 48'({1'b1, w_b.frac})) >> 23);
   // Biased exponent sum still carrying one extra bias.
   assign w_esum = 10'(w_a.exp) + 10'(w_b.exp) + 10'(w_top[24]);

   always_comb begin
      o_sign     = w_a.sign ^ w_b.sign;
      o_exp      = '0;
      o_frac     = '0;
      o_error    = 1'b0;
      o_overflow = 1'b0;
      if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
         o_exp   = EXP_MAX;
         o_frac  = 23'h400000;
         o_error = 1'b1;
      end else if (w_a_inf || w_b_inf) begin
         o_exp = EXP_MAX;
      end else if (!(w_a_zero || w_b_zero)) begin
         if (w_esum >= 10'(EXP_BIAS + 32'(EXP_MAX))) begin
            o_exp      = EXP_MAX;
            o_overflow = 1'b1;
         end else if (w_esum > 10'(EXP_BIAS)) begin
            o_exp  = 8'(w_esum - 10'(EXP_BIAS));
            o_frac = w_top[24] ? w_top[23:1] : w_top[22:0];
         end
         // else underflow: signed zero
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches upward from (i_ptr+1) mod N
// with wrap-around and grants the first asserted request.
//   i_req   : request vector
//   i_ptr   : index of the last granted requester
//   i_adv   : downstream can accept; gates the one-hot grant only
//   o_grant : one-hot grant (zero when no request or !i_adv)
//   o_idx   : granted index (valid when o_any)
//   o_any   : at least one request asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   input  logic          i_adv,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      // Walk the search order backwards so the closest candidate to ptr+1
      // is the last one written and therefore wins.
      for (int unsigned k = N; k >= 1; k--) begin
         int unsigned w_cand;
         w_cand = (32'(i_ptr) + k) % N;
         if (i_req[IW'(w_cand)]) begin
            o_idx = IW'(w_cand);
            o_any = 1'b1;
         end
      end
      o_grant[o_idx] = o_any & i_adv;
   end

endmodule

// File: rtl/fmul_rr_sched.sv
// -----------------------------------------------------------------------------
// fmul_rr_sched
// Round-robin scheduler sharing one fmul_core among NREQ requesters through a
// 2-stage pipeline (operand register -> multiplier -> result register).
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid     : per-requester operation request
//   req_ready     : per-requester acceptance (one-hot or zero)
//   req_a, req_b  : operands, slice i = bits [32i+31:32i]
//   resp_valid    : result available
//   resp_ready    : consumer accepts result
//   resp_id       : requester index of the result
//   resp_data     : packed binary32 result
//   resp_error    : invalid operation (inf * 0)
//   resp_overflow : exponent overflow
//   busy          : any pipeline stage occupied
// Optional (macro FMUL_SCHED_STATS_EN): parameter CNTW, input stat_clr and
// saturating counters stat_ops / stat_err / stat_ovf on response handshakes.
// -----------------------------------------------------------------------------
module fmul_rr_sched
   import fp_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
`ifdef FMUL_SCHED_STATS_EN
   ,
   parameter int CNTW = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [31:0]          resp_data,
   output logic                 resp_error,
   output logic                 resp_overflow,
   output logic                 busy
`ifdef FMUL_SCHED_STATS_EN
   ,
   input  logic                 stat_clr,
   output logic [CNTW-1:0]      stat_ops,
   output logic [CNTW-1:0]      stat_err,
   output logic [CNTW-1:0]      stat_ovf
`endif
);

   logic            r_s1_valid, r_s2_valid;
   logic [31:0]     r_s1_a, r_s1_b;
   logic [IDW-1:0]  r_s1_id, r_s2_id, r_ptr;
   logic            r_s2_sign, r_s2_err, r_s2_ovf;
   logic [7:0]      r_s2_exp;
   logic [23:1]     r_s2_frac;

   logic            w_adv1, w_adv2, w_any, w_xfer;
   logic [IDW-1:0]  w_gidx;
   logic            w_sign, w_err, w_ovf;
   logic [7:0]      w_exp;
   logic [23:1]     w_frac;

   assign w_adv2 = !r_s2_valid || resp_ready;
   assign w_adv1 = !r_s1_valid || w_adv2;
   assign w_xfer = w_any && w_adv1;

   rr_arbiter #(
      .N  (NREQ),
      .IW (IDW)
   ) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .i_adv   (w_adv1),
      .o_grant (req_ready),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

   fmul_core u_fmul (
      .i_a        (r_s1_a),
      .i_b        (r_s1_b),
      .o_sign     (w_sign),
      .o_exp      (w_exp),
      .o_frac     (w_frac),
      .o_error    (w_err),
      .o_overflow (w_ovf)
   );

   // Stage 1: operand register and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_id    <= '0;
         r_ptr      <= IDW'(NREQ - 1);
      end else if (w_adv1) begin
         r_s1_valid <= w_xfer;
         if (w_xfer) begin
            r_s1_a  <= req_a[{w_gidx, 5'd0} +: 32];
            r_s1_b  <= req_b[{w_gidx, 5'd0} +: 32];
            r_s1_id <= w_gidx;
            r_ptr   <= w_gidx;
         end
      end
   end

   // Stage 2: result register, drives the response bus directly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_id    <= '0;
         r_s2_sign  <= 1'b0;
         r_s2_exp   <= '0;
         r_s2_frac  <= '0;
         r_s2_err   <= 1'b0;
         r_s2_ovf   <= 1'b0;
      end else if (w_adv2) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_id   <= r_s1_id;
            r_s2_sign <= w_sign;
            r_s2_exp  <= w_exp;
            r_s2_frac <= w_frac;
            r_s2_err  <= w_err;
            r_s2_ovf  <= w_ovf;
         end
      end
   end

   assign resp_valid    = r_s2_valid;
   assign resp_id       = r_s2_id;
   assign resp_data     = fp32_pack(r_s2_sign, r_s2_exp, r_s2_frac);
   assign resp_error    = r_s2_err;
   assign resp_overflow = r_s2_ovf;
   assign busy          = r_s1_valid || r_s2_valid;

`ifdef FMUL_SCHED_STATS_EN
   logic            w_rsp_hs;
   logic [CNTW-1:0] r_ops, r_err, r_ovf;

   assign w_rsp_hs = r_s2_valid && resp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ops <= '0;
         r_err <= '0;
         r_ovf <= '0;
      end else if (stat_clr) begin
         r_ops <= '0;
         r_err <= '0;
         r_ovf <= '0;
      end else if (w_rsp_hs) begin
         if (r_ops != '1)             r_ops <= r_ops + 1'b1;
         if (r_s2_err && r_err != '1) r_err <= r_err + 1'b1;
         if (r_s2_ovf && r_ovf != '1) r_ovf <= r_ovf + 1'b1;
      end
   end

   assign stat_ops = r_ops;
   assign stat_err = r_err;
   assign stat_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_fmul_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_fmul_rr_sched
// Scoreboard bench for fmul_rr_sched: expected responses are queued when a
// request handshake is seen and compared by a monitor on the response bus.
// Define FMUL_SCHED_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_fmul_rr_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid, req_ready;
   logic [NREQ*32-1:0]  req_a, req_b;
   logic                resp_valid, resp_ready;
   logic [IDW-1:0]      resp_id;
   logic [31:0]         resp_data;
   logic                resp_error, resp_overflow, busy;
`ifdef FMUL_SCHED_STATS_EN
   logic                stat_clr;
   logic [15:0]         stat_ops, stat_err, stat_ovf;
`endif

   always #5 clk = ~clk;

   fmul_rr_sched #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_id       (resp_id),
      .resp_data     (resp_data),
      .resp_error    (resp_error),
      .resp_overflow (resp_overflow),
      .busy          (busy)
`ifdef FMUL_SCHED_STATS_EN
      ,
      .stat_clr      (stat_clr),
      .stat_ops      (stat_ops),
      .stat_err      (stat_err),
      .stat_ovf      (stat_ovf)
`endif
   );

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [31:0]    data;
      logic           err;
      logic           ovf;
   } exp_t;

   exp_t            sb[$];
   exp_t            pend[NREQ];
   int unsigned     glog[$];
   int              n_pass  = 0;
   int              n_total = 0;
   logic [NREQ-1:0] hs;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
   endtask

   task automatic set_op(input int unsigned i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic e, input logic o);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      pend[i] = '{id: IDW'(i), data: d, err: e, ovf: o};
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Hold requests until each is accepted, dropping accepted bits.
   task automatic drain_reqs(input int unsigned maxcyc);
      logic [NREQ-1:0] h;
      int unsigned c;
      c = 0;
      while (req_valid != '0 && c < maxcyc) begin
         @(negedge clk);
         h = req_valid & req_ready;
         tick();
         req_valid = req_valid & ~h;
         c++;
      end
      check("req_accept_timeout", 32'(req_valid), 0);
   endtask

   task automatic wait_empty(input int unsigned maxcyc);
      int unsigned c;
      c = 0;
      while (sb.size() != 0 && c < maxcyc) begin
         tick();
         c++;
      end
      check("scoreboard_drain", sb.size(), 0);
   endtask

   // Monitor / scoreboard: compares the head whenever a result is presented
   // (so a stalled result must stay equal), pops on handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (resp_valid) begin
            if (sb.size() == 0) begin
               check("resp_unexpected", 32'(resp_valid), 0);
            end else begin
               check("resp_id",       32'(resp_id),       32'(sb[0].id));
               check("resp_data",     resp_data,          sb[0].data);
               check("resp_error",    32'(resp_error),    32'(sb[0].err));
               check("resp_overflow", 32'(resp_overflow), 32'(sb[0].ovf));
               if (resp_ready) void'(sb.pop_front());
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb.push_back(pend[i]);
               glog.push_back(i);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
`ifdef FMUL_SCHED_STATS_EN
      stat_clr   = 1'b0;
`endif
      for (int i = 0; i < NREQ; i++) pend[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_busy",       32'(busy),       0);
      check("rst_req_ready",  32'(req_ready),  0);
      check("rst_resp_data",  resp_data,       0);
      check("rst_resp_flags", {30'b0, resp_error, resp_overflow}, 0);
      tick();
      rst = 1'b0;
      tick();

      // Basic multiply, 2-cycle latency
      set_op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
      req_valid = 4'b0001;
      @(negedge clk);
      check("basic_req_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("basic_lat1_resp_valid", 32'(resp_valid), 0);
      check("basic_lat1_busy",       32'(busy),       1);
      @(negedge clk);
      check("basic_lat2_resp_valid", 32'(resp_valid), 1);
      tick();
      wait_empty(8);

      // Specials
      set_op(0, 32'hFF800000, 32'h00000000, 32'hFFC00000, 1'b1, 1'b0);
      set_op(1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0);
      set_op(2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 1'b1);
      set_op(3, 32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
      req_valid = 4'b1111;
      drain_reqs(10);
      wait_empty(10);

      // Underflow and denormal-as-zero
      set_op(2, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b0);
      set_op(3, 32'h00400000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
      req_valid = 4'b1100;
      drain_reqs(10);
      wait_empty(10);

      // Backpressure: full pipeline blocks further acceptance
      glog.delete();
      set_op(0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);
      set_op(1, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0);
      set_op(2, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
      resp_ready = 1'b0;
      req_valid  = 4'b0111;
      repeat (5) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         tick();
         req_valid = req_valid & ~hs;
      end
      check("bp_handshakes", glog.size(), 2);
      if (glog.size() >= 2) begin
         check("bp_grant0", glog[0], 0);
         check("bp_grant1", glog[1], 1);
      end
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready),  0);
      check("bp_busy",      32'(busy),       1);
      check("bp_stable",    resp_data,       32'h40100000);
      tick();
      resp_ready = 1'b1;
      drain_reqs(10);
      wait_empty(10);
      check("bp_total_grants", glog.size(), 3);
      if (glog.size() >= 3) check("bp_grant2", glog[2], 2);

      // Reset while s1 and s2 hold entries
      resp_ready = 1'b0;
      set_op(3, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0);
      set_op(1, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
      req_valid = 4'b1010;
      drain_reqs(10);
      @(negedge clk);
      check("mid_busy_before",       32'(busy),       1);
      check("mid_resp_valid_before", 32'(resp_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_resp_valid_after", 32'(resp_valid), 0);
      check("mid_busy_after",       32'(busy),       0);
      check("mid_resp_data_after",  resp_data,       0);
      sb.delete();
      tick();
      rst        = 1'b0;
      resp_ready = 1'b1;
      tick();

      // Round-robin after reset: requester 0 first, one grant per cycle
      glog.delete();
      set_op(0, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0);
      set_op(1, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
      set_op(2, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0);
      req_valid = 4'b0111;
      repeat (6) tick();
      req_valid = '0;
      check("rr_grant_count", glog.size(), 6);
      for (int k = 0; k < 6; k++) begin
         if (k < glog.size()) check("rr_grant_order", glog[k], 32'(k % 3));
      end
      wait_empty(10);

`ifdef FMUL_SCHED_STATS_EN
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      set_op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
      set_op(1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0);
      set_op(2, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
      req_valid = 4'b0111;
      drain_reqs(10);
      wait_empty(10);
      tick();
      @(negedge clk);
      check("stat_ops", 32'(stat_ops), 3);
      check("stat_err", 32'(stat_err), 1);
      check("stat_ovf", 32'(stat_ovf), 0);
      tick();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      @(negedge clk);
      check("stat_clr_ops", 32'(stat_ops), 0);
      check("stat_clr_err", 32'(stat_err), 0);
      check("stat_clr_ovf", 32'(stat_ovf), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
